concat_row_reader: RTL
======================

// Module: concat_row_reader
// PURPOSE
//  Downstream consumer of the concat read FIFO. Waits for the FIFO's M_Ready,
//  pulls one feature-map row (row_words entries) per burst, and streams it out
//  with a valid strobe. Counts rows to row_num, then pulses done. Sits between
//  the concat read FIFO and the next TJPU compute/write stage.
// PARAMETERS
//  WIDTH      128  data word width; matches the FIFO's WIDTH
//  ADDR_BITS  10   FIFO depth log2; sets the width of row_words and M_count
// PORTS
//  clk         in   1             system clock
//  rst         in   1             synchronous reset, active high
//  start       in   1             1-cycle pulse; latches row_words and row_num
//  row_words   in   ADDR_BITS+1   FIFO entries per row
//  row_num     in   16            rows per frame
//  M_count     out  ADDR_BITS+1   drives FIFO M_count; equals the latched row_words
//  M_Ready     in   1             from FIFO; registered (data_count >= M_count)
//  fifo_rd_en  out  1             FIFO read strobe
//  fifo_dout   in   WIDTH         FIFO read data; valid 1 cycle after rd_en
//  out_ready   in   1             downstream can accept a complete row
//  dout        out  WIDTH         output data
//  dout_valid  out  1             dout qualifier
//  busy        out  1             high from start until done
//  done        out  1             1-cycle pulse after the last word of the last row
// BEHAVIOUR
//  Reset values: fifo_rd_en=0, dout=0, dout_valid=0, busy=0, done=0, M_count=0.
//  State machine:
//  - IDLE: on start, latch row_words/row_num, zero the counters, set busy.
//    If row_words==0 or row_num==0, go to DONE; otherwise go to WAIT.
//  - WAIT: if M_Ready && out_ready, go to READ.
//  - READ: fifo_rd_en=1 for exactly row_words consecutive cycles; word_cnt counts them.
//    On the last word, increment row_cnt and go to GAP.
//  - GAP: hold for 2 cycles, because M_Ready is registered and lags data_count.
//    Then go to WAIT, or to DONE if row_cnt==row_num.
//  - DONE: done=1 for 1 cycle, busy=0, return to IDLE.
//  Datapath:
//  - dout_valid = fifo_rd_en delayed 1 cycle; dout = fifo_dout on that cycle.
//  - dout holds its last value when dout_valid=0.
//  - The DONE pulse follows the last dout_valid by at least 1 cycle.
//  - No backpressure inside a row: out_ready is sampled only in WAIT.
//  Boundary conditions:
//  - start while busy is ignored. Changes to row_words/row_num mid-frame are ignored.
//  - M_Ready may drop during READ (entries are being consumed); it is not re-checked until WAIT.
//  - Counters: word_cnt is ADDR_BITS+1 bits, row_cnt is 16 bits; both compare with ==, no wrap.
//  - rst mid-operation: return to IDLE within 1 cycle, with rd_en and valid low that same cycle.
//    Any in-flight FIFO word is discarded.
// CONFIGURATION
//  CONCAT_ROW_PAD_EN defined:
//  - Every output row becomes 1 zero word + row_words FIFO words + 1 zero word (row_words+2 words).
//  - PAD_L state sits before READ and PAD_R state after READ; each lasts 1 cycle with
//    dout=0, dout_valid=1, fifo_rd_en=0.
//  - Output stays contiguous: the PAD_L word, then the row_words FIFO words, then the
//    PAD_R word, with no gaps.
//  - FIFO traffic and M_count are unchanged.
//  CONCAT_ROW_PAD_EN undefined: no PAD states; rows are exactly row_words words.
// TESTING
//  T1 row_words=4, row_num=3, M_Ready=1, out_ready=1
//     -> 3 bursts of 4 rd_en cycles, 12 valid words in FIFO order, 2-cycle gaps, 1 done pulse.
//  T2 M_Ready=0 for 20 cycles after start
//     -> no rd_en; the first rd_en comes 1 cycle after M_Ready rises.
//  T3 out_ready=0 in WAIT while M_Ready=1
//     -> stays in WAIT; a burst starts 1 cycle after out_ready goes high.
//  T4 start with row_num=0, and start with row_words=0
//     -> no rd_en, done 2 cycles after start.
//  T5 rst asserted mid-burst (word 2 of 4)
//     -> next cycle rd_en=0, valid=0, busy=0; a fresh start runs normally.
//  T6 CONCAT_ROW_PAD_EN, row_words=2, row_num=1
//     -> dout = 0, A, B, 0 valid on 4 consecutive cycles.

Source files
------------

// File: rtl/concat_row_reader.sv
// concat_row_reader
//   Downstream consumer of the concat read FIFO. After a start pulse it waits
//   for the FIFO to report a full row (M_Ready) and for the consumer to accept
//   one (out_ready). It then bursts row_words reads and streams the words out
//   with a valid strobe. It repeats this for row_num rows and then pulses done.
//
//   Optional feature (macro CONCAT_ROW_PAD_EN): each output row is framed by
//   one zero word on each side, giving row_words+2 contiguous valid words.
//   FIFO traffic and M_count are the same in both builds.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   start        1-cycle pulse; latches row_words/row_num (ignored while busy)
//   row_words    FIFO entries per row
//   row_num      rows per frame
//   M_count      FIFO threshold; the latched row_words
//   M_Ready      FIFO has at least M_count entries (registered in the FIFO)
//   fifo_rd_en   FIFO read strobe
//   fifo_dout    FIFO read data, valid the cycle after fifo_rd_en
//   out_ready    downstream can take a whole row; sampled only between rows
//   dout         output word; holds its last value while dout_valid is low
//   dout_valid   dout qualifier
//   busy         high from an accepted start until done
//   done         1-cycle pulse after the last word of the frame
module concat_row_reader #(
    parameter int WIDTH     = 128,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS:0]   row_words,
    input  logic [15:0]          row_num,
    output logic [ADDR_BITS:0]   M_count,
    input  logic                 M_Ready,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_dout,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PAD_L,
        S_READ,
        S_PAD_R,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [ADDR_BITS:0] W_ONE = 1;
    localparam logic [15:0]        R_ONE = 16'd1;

    state_t               state;
    state_t               state_nxt;
    logic [ADDR_BITS:0]   rw_q;
    logic [15:0]          rn_q;
    logic [ADDR_BITS:0]   word_cnt;
    logic [15:0]          row_cnt;
    logic                 gap_cnt;
    logic                 busy_q;
    logic                 done_q;
    logic                 rd_d;      // read issued last cycle: fifo_dout is live now
    logic                 pad_d;     // pad word issued last cycle
    logic [WIDTH-1:0]     dout_q;    // last word shown, held while idle
    logic                 last_word;

    // rw_q is never zero in READ: a zero row_words goes straight to DONE.
    assign last_word = (word_cnt == rw_q - W_ONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (row_words == '0 || row_num == '0)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (M_Ready && out_ready) begin
`ifdef CONCAT_ROW_PAD_EN
                    state_nxt = S_PAD_L;
`else
                    state_nxt = S_READ;
`endif
                end
            end
`ifdef CONCAT_ROW_PAD_EN
            S_PAD_L: state_nxt = S_READ;
            S_PAD_R: state_nxt = S_GAP;
`endif
            S_READ: begin
                if (last_word) begin
`ifdef CONCAT_ROW_PAD_EN
                    state_nxt = S_PAD_R;
`else
                    state_nxt = S_GAP;
`endif
                end
            end
            // Two idle cycles let the FIFO's registered M_Ready catch up with
            // the entries just consumed before it is trusted again in WAIT.
            S_GAP: begin
                if (gap_cnt)
                    state_nxt = (row_cnt == rn_q) ? S_DONE : S_WAIT;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rw_q     <= '0;
            rn_q     <= '0;
            word_cnt <= '0;
            row_cnt  <= '0;
            gap_cnt  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_d     <= 1'b0;
            pad_d    <= 1'b0;
            dout_q   <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= 1'b0;
            rd_d   <= (state == S_READ);
            pad_d  <= (state == S_PAD_L) || (state == S_PAD_R);

            if (rd_d)
                dout_q <= fifo_dout;
            else if (pad_d)
                dout_q <= '0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        rw_q     <= row_words;
                        rn_q     <= row_num;
                        word_cnt <= '0;
                        row_cnt  <= '0;
                        gap_cnt  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                S_READ: begin
                    if (last_word) begin
                        word_cnt <= '0;
                        row_cnt  <= row_cnt + R_ONE;
                    end else begin
                        word_cnt <= word_cnt + W_ONE;
                    end
                end
                S_GAP:  gap_cnt <= ~gap_cnt;
                S_DONE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The FIFO presents data one cycle after the read, so the output is
    // muxed straight from fifo_dout on that cycle instead of registered again.
    assign fifo_rd_en = (state == S_READ);
    assign dout_valid = rd_d | pad_d;
    assign dout       = rd_d ? fifo_dout : (pad_d ? '0 : dout_q);
    assign busy       = busy_q;
    assign done       = done_q;
    assign M_count    = rw_q;

endmodule
